// File: rtl/apex_metadata.sv
// Metadata register block for the APEX attestation path: holds ER/OR bounds and
// turns the atomicity monitor's per-cycle exec flag into a sticky EXEC proof bit.
module apex_metadata #(
    parameter logic [13:0] BASE_ADDR = 14'h0070
) (
    input  logic        clk,
    input  logic        puc_rst,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    input  logic [15:0] pc,
    input  logic        exec_in,
    output logic [15:0] er_min,
    output logic [15:0] er_max,
    output logic [15:0] or_min,
    output logic [15:0] or_max,
    output logic        exec_flag
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        RUNNING = 2'b10,
        DONE    = 2'b11
    } state_t;

    state_t      state_q;
    logic [15:0] er_min_q, er_max_q, or_min_q, or_max_q;
    logic [15:0] er_min_d, er_max_d, or_min_d, or_max_d;
    logic        last_was_max_q;

    logic [13:0] offset;
    logic        decoded;
    logic        bus_wr;
    logic        cfg_wr;
    logic        arm_wr;
    logic        pc_in_er;
    logic        er_valid;

    // Below-base addresses wrap to large offsets, so a single compare decodes the window.
    assign offset   = per_addr - BASE_ADDR;
    assign decoded  = (offset < 14'd8);
    assign bus_wr   = per_en && (per_we != 2'b00) && decoded;
    assign cfg_wr   = bus_wr && (offset < 14'd4);
    assign arm_wr   = bus_wr && (offset == 14'd4) && per_we[0] && per_din[0];
    assign pc_in_er = (pc >= er_min_q) && (pc <= er_max_q);
    assign er_valid = (er_min_q <= er_max_q);

    function automatic logic [15:0] mergeBytes(input logic [15:0] old,
                                               input logic [15:0] din,
                                               input logic [1:0]  we);
        logic [15:0] res;
        res       = old;
        if (we[0]) res[7:0]  = din[7:0];
        if (we[1]) res[15:8] = din[15:8];
        return res;
    endfunction

    always_comb begin
        er_min_d = er_min_q;
        er_max_d = er_max_q;
        or_min_d = or_min_q;
        or_max_d = or_max_q;
        if (cfg_wr && (state_q == IDLE)) begin
            case (offset[1:0])
                2'd0: er_min_d = mergeBytes(er_min_q, per_din, per_we);
                2'd1: er_max_d = mergeBytes(er_max_q, per_din, per_we);
                2'd2: or_min_d = mergeBytes(or_min_q, per_din, per_we);
                default: or_max_d = mergeBytes(or_max_q, per_din, per_we);
            endcase
        end
    end

    // Bus writes (config lock, ARM) outrank every pc-driven transition.
    always_ff @(posedge clk) begin
        if (puc_rst) begin
            state_q        <= IDLE;
            last_was_max_q <= 1'b0;
            er_min_q       <= 16'h0000;
            er_max_q       <= 16'h0000;
            or_min_q       <= 16'h0000;
            or_max_q       <= 16'h0000;
        end else begin
            last_was_max_q <= (pc == er_max_q);
            er_min_q       <= er_min_d;
            er_max_q       <= er_max_d;
            or_min_q       <= or_min_d;
            or_max_q       <= or_max_d;
            if (cfg_wr) begin
                if (state_q != IDLE) state_q <= IDLE;
            end else if (arm_wr) begin
                state_q <= ARMED;
            end else begin
                case (state_q)
                    ARMED: if (pc == er_min_q) state_q <= RUNNING;
                    RUNNING: begin
                        if (!exec_in) state_q <= IDLE;
                        else if (last_was_max_q && !pc_in_er && er_valid) state_q <= DONE;
                    end
                    DONE: begin
                        if (!exec_in) state_q <= IDLE;
                        else if (pc == er_min_q) state_q <= RUNNING;
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    always_comb begin
        per_dout = 16'h0000;
        if (per_en && (per_we == 2'b00) && decoded) begin
            case (offset[2:0])
                3'd0: per_dout = er_min_q;
                3'd1: per_dout = er_max_q;
                3'd2: per_dout = or_min_q;
                3'd3: per_dout = or_max_q;
                3'd4: per_dout = {13'b0, (state_q == DONE), state_q};
                default: per_dout = 16'h0000;
            endcase
        end
    end

    assign er_min    = er_min_q;
    assign er_max    = er_max_q;
    assign or_min    = or_min_q;
    assign or_max    = or_max_q;
    assign exec_flag = (state_q == DONE);

endmodule
